if_fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the IF/ID pipeline register.
- Holds the program counter and issues one single-outstanding request at a time to instruction memory.
- Captures the returned word and presents pc_o/instr_o/valid_o to IF/ID as PC_IN/DATA_IN.
- Handles downstream stall and branch/jump redirect, including killing an in-flight fetch.

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// One request pulse per fetch; the response returns one or more cycles later.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, stall and redirect handling.
// Optional macro IF_MISALIGN_TRAP_EN: misaligned redirects raise sticky misalign_o and halt.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_o,
  output logic [31:0]            instr_o,
  output logic                   valid_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {StReq, StWait, StValid, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic        redir_bad;
  logic [31:0] redir_pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redir_pc  = redirect_pc_i;
`else
  assign redir_bad = 1'b0;
  assign redir_pc  = {redirect_pc_i[31:2], 2'b00};
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    unique case (state_q)
      StReq: begin
        state_d = StWait;
        // The request at the old pc is already out; its data must be dropped.
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          kill_d     = 1'b1;
        end
      end
      StWait: begin
        if (imem.rvalid) begin
          if (kill_q || redirect_i) begin
            kill_d  = 1'b0;
            state_d = StReq;
            if (redirect_i) begin
              fetch_pc_d = redir_pc;
            end
          end else begin
            instr_d = imem.rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = StValid;
          end
        end else if (redirect_i) begin
          fetch_pc_d = redir_pc;
          kill_d     = 1'b1;
        end
      end
      StValid: begin
        // Redirect outranks stall: the held instruction is on the wrong path.
        if (redirect_i) begin
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          fetch_pc_d = redir_pc;
          state_d    = StReq;
        end else if (!stall_i) begin
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StReq;
        end
      end
      StHalt: begin
        if (redirect_i && !redir_bad) begin
          misalign_d = 1'b0;
          fetch_pc_d = redir_pc;
          state_d    = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Misaligned target parks the fetch unit regardless of the current state.
    if (redir_bad) begin
      state_d    = StHalt;
      fetch_pc_d = redir_pc;
      kill_d     = 1'b0;
      misalign_d = 1'b1;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.req   = (state_q == StReq);
  assign imem.addr  = fetch_pc_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;
  assign misalign_o = misalign_q;

  // A response with no request outstanding is a memory protocol error.
  assert property (@(posedge clk) disable iff (rst)
    imem.rvalid |-> (state_q inside {StWait, StHalt}));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: latency-programmable memory responder,
// transaction-level reference monitor and directed plus randomized scenarios.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o, instr_o;
  logic        valid_o, misalign_o;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;   // 0 selects a random latency of 1..4 per request
  logic [31:0] salt;
  int          req_cyc_q[$];
  logic [31:0] req_addr_q[$];
  logic [31:0] deliv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: answers each request after the configured latency.
  initial begin
    logic [31:0] a;
    int          lat;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && imem_bus.req) begin
        a   = imem_bus.addr;
        lat = (mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4));
        @(posedge clk); #1;
        repeat (lat - 1) begin
          @(posedge clk); #1;
        end
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = mem_word(a);
        @(posedge clk); #1;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = $urandom;
      end
    end
  end

  // Reference: what the stage owes downstream, tracked per transaction.
  initial begin
    logic [31:0] m_next, m_addr, m_pc, tgt;
    logic        m_out, m_kill, m_valid, m_halt, exp_req, got;
    m_next = RESET_PC; m_addr = '0; m_pc = '0;
    m_out = 1'b0; m_kill = 1'b0; m_valid = 1'b0; m_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_next = RESET_PC; m_out = 1'b0; m_kill = 1'b0; m_valid = 1'b0; m_halt = 1'b0;
      end else begin
        n_checks++;
        if (valid_o !== m_valid) begin
          n_fail++;
          $display("FAIL mon_valid cyc=%0d got=%b exp=%b", cyc, valid_o, m_valid);
        end
        n_checks++;
        if (m_valid) begin
          if (pc_o !== m_pc || instr_o !== mem_word(m_pc)) begin
            n_fail++;
            $display("FAIL mon_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, pc_o, instr_o, m_pc, mem_word(m_pc));
          end
        end else if (instr_o !== NOP_INSTR) begin
          n_fail++;
          $display("FAIL mon_nop cyc=%0d got=%h exp=%h", cyc, instr_o, NOP_INSTR);
        end
        exp_req = !m_out && !m_valid && !m_halt;
        n_checks++;
        if (imem_bus.req !== exp_req) begin
          n_fail++;
          $display("FAIL mon_req cyc=%0d got=%b exp=%b", cyc, imem_bus.req, exp_req);
        end
        if (imem_bus.req && exp_req) begin
          n_checks++;
          if (imem_bus.addr !== m_next) begin
            n_fail++;
            $display("FAIL mon_addr cyc=%0d got=%h exp=%h", cyc, imem_bus.addr, m_next);
          end
          req_cyc_q.push_back(cyc);
          req_addr_q.push_back(imem_bus.addr);
        end
        n_checks++;
        if (misalign_o !== m_halt) begin
          n_fail++;
          $display("FAIL mon_misalign cyc=%0d got=%b exp=%b", cyc, misalign_o, m_halt);
        end
        // Events of this cycle decide what is owed next cycle.
        got = 1'b0;
        if (imem_bus.rvalid && m_out) begin
          m_out = 1'b0;
          got   = !m_kill && !redirect_i;
        end
        if (imem_bus.req) begin
          m_out  = 1'b1;
          m_kill = 1'b0;
          m_addr = imem_bus.addr;
        end
        if (m_valid && (redirect_i || !stall_i)) begin
          m_valid = 1'b0;
          if (!redirect_i) m_next = m_pc + 32'd4;
        end
        if (redirect_i) begin
          tgt = redirect_pc_i;
`ifdef IF_MISALIGN_TRAP_EN
          if (tgt[1:0] != 2'b00) begin
            m_halt = 1'b1; m_next = tgt; m_valid = 1'b0; m_out = 1'b0; m_kill = 1'b0;
          end else begin
            m_halt = 1'b0; m_next = tgt;
            if (m_out) m_kill = 1'b1;
          end
`else
          m_next = {tgt[31:2], 2'b00};
          if (m_out) m_kill = 1'b1;
`endif
        end
        if (got) begin
          m_valid = 1'b1;
          m_pc    = m_addr;
          deliv_q.push_back(m_addr);
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_req_at(input logic [31:0] a, input int budget, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_bus.req && imem_bus.addr == a) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s timeout waiting req addr=%h got=%h", tag, a, imem_bus.addr);
    end
  endtask

  task automatic wait_valid_at(input logic [31:0] a, input int budget, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid_o && pc_o == a) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s timeout waiting valid pc=%h got=%h", tag, a, pc_o);
    end
  endtask

  task automatic test_reset();
    mem_lat = 1;
    apply_reset();
    wait_valid_at(32'h4, 40, "reset_pre");
    #2 rst = 1'b1;   // mid-cycle, well before the next edge
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP_INSTR || pc_o !== RESET_PC ||
        imem_bus.req !== 1'b1 || imem_bus.addr !== RESET_PC || misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals got v=%b i=%h pc=%h req=%b a=%h m=%b exp 0/%h/%h/1/%h/0",
               valid_o, instr_o, pc_o, imem_bus.req, imem_bus.addr, misalign_o,
               NOP_INSTR, RESET_PC, RESET_PC);
    end
  endtask

  task automatic test_basic();
    int ri, di;
    mem_lat = 1;
    apply_reset();
    ri = req_addr_q.size();
    di = deliv_q.size();
    for (int i = 0; i < 30 && req_addr_q.size() < ri + 3; i++) @(posedge clk);
    n_checks++;
    if (req_addr_q.size() < ri + 3) begin
      n_fail++;
      $display("FAIL basic_reqs got=%0d exp=3", req_addr_q.size() - ri);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (req_addr_q[ri + k] !== 32'(4 * k)) begin
          n_fail++;
          $display("FAIL basic_addr%0d got=%h exp=%h", k, req_addr_q[ri + k], 32'(4 * k));
        end
      end
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (req_cyc_q[ri + k] - req_cyc_q[ri + k - 1] != 3) begin
          n_fail++;
          $display("FAIL basic_period got=%0d exp=3", req_cyc_q[ri + k] - req_cyc_q[ri + k - 1]);
        end
      end
      n_checks++;
      if (deliv_q.size() < di + 2 || deliv_q[di] !== 32'h0 || deliv_q[di + 1] !== 32'h4) begin
        n_fail++;
        $display("FAIL basic_deliv got count=%0d exp first pcs 0,4", deliv_q.size() - di);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    mem_lat = 1;
    apply_reset();
    wait_valid_at(32'h4, 40, "stall_pre");
    stall_i = 1'b1;
    held = instr_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== held || imem_bus.req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold got v=%b pc=%h i=%h req=%b exp 1/4/%h/0",
                 valid_o, pc_o, instr_o, imem_bus.req, held);
      end
    end
    stall_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h8 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release got req=%b a=%h v=%b exp 1/8/0",
               imem_bus.req, imem_bus.addr, valid_o);
    end
  endtask

  task automatic test_redirect_wait();
    logic saw_valid = 1'b0;
    mem_lat = 3;
    apply_reset();
    wait_req_at(RESET_PC, 5, "rdw_pre");
    @(posedge clk); #1;
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    for (int i = 0; i < 8 && !imem_bus.req; i++) begin
      if (valid_o) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (saw_valid || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_wait got v_seen=%b req=%b a=%h exp 0/1/100",
               saw_valid, imem_bus.req, imem_bus.addr);
    end
  endtask

  task automatic test_redirect_collide();
    mem_lat = 2;
    apply_reset();
    wait_req_at(RESET_PC, 5, "coll_pre");
    repeat (2) @(posedge clk);
    #1;
    redirect_i = 1'b1; redirect_pc_i = 32'h200;   // same cycle as rvalid
    @(posedge clk); #1;
    redirect_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin
      n_fail++;
      $display("FAIL collide_rvalid got v=%b req=%b a=%h exp 0/1/200",
               valid_o, imem_bus.req, imem_bus.addr);
    end
    wait_valid_at(32'h200, 10, "coll_valid");
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h340;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP_INSTR || imem_bus.req !== 1'b1 ||
        imem_bus.addr !== 32'h340) begin
      n_fail++;
      $display("FAIL collide_stall got v=%b i=%h req=%b a=%h exp 0/%h/1/340",
               valid_o, instr_o, imem_bus.req, imem_bus.addr, NOP_INSTR);
    end
    stall_i = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    mem_lat = 4;
    apply_reset();
    wait_valid_at(32'h4, 40, "rmw_pre");
    wait_req_at(32'h8, 10, "rmw_req");
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || pc_o !== RESET_PC || instr_o !== NOP_INSTR ||
        imem_bus.req !== 1'b1 || imem_bus.addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rst_async got v=%b pc=%h i=%h req=%b a=%h exp 0/%h/%h/1/%h",
               valid_o, pc_o, instr_o, imem_bus.req, imem_bus.addr,
               RESET_PC, NOP_INSTR, RESET_PC);
    end
    repeat (5) @(posedge clk);   // late response lands while rst is held
    #1 rst = 1'b0;
    n_checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL rst_restart got req=%b a=%h exp 1/%h", imem_bus.req, imem_bus.addr, RESET_PC);
    end
    wait_valid_at(RESET_PC, 10, "rst_refetch");
    n_checks++;
    if (instr_o !== mem_word(RESET_PC)) begin
      n_fail++;
      $display("FAIL rst_refetch_data got=%h exp=%h", instr_o, mem_word(RESET_PC));
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    apply_reset();
    wait_valid_at(RESET_PC, 10, "wrap_pre");
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    wait_valid_at(32'hFFFF_FFFC, 10, "wrap_valid");
    @(posedge clk); #1;
    n_checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addr got req=%b a=%h exp 1/00000000", imem_bus.req, imem_bus.addr);
    end
  endtask

  task automatic test_misalign();
    mem_lat = 1;
    apply_reset();
    wait_valid_at(RESET_PC, 10, "mis_pre");
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    @(posedge clk); #1;
    redirect_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (misalign_o !== 1'b1 || imem_bus.req !== 1'b0 || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_halt got m=%b req=%b v=%b exp 1/0/0",
                 misalign_o, imem_bus.req, valid_o);
      end
      @(posedge clk); #1;
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    @(posedge clk); #1;
    redirect_i = 1'b0;
    n_checks++;
    if (misalign_o !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h200) begin
      n_fail++;
      $display("FAIL misalign_clear got m=%b req=%b a=%h exp 0/1/200",
               misalign_o, imem_bus.req, imem_bus.addr);
    end
    wait_valid_at(32'h200, 10, "misalign_fetch");
`else
    n_checks++;
    if (misalign_o !== 1'b0 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h100) begin
      n_fail++;
      $display("FAIL align_force got m=%b req=%b a=%h exp 0/1/100",
               misalign_o, imem_bus.req, imem_bus.addr);
    end
`endif
  endtask

  task automatic test_random();
    int          di;
    logic [31:0] tgt;
    mem_lat = 0;
    apply_reset();
    di = deliv_q.size();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      stall_i    = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef IF_MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      redirect_pc_i = tgt;
    end
    @(posedge clk); #1;
    stall_i = 1'b0; redirect_i = 1'b0;
    repeat (10) @(posedge clk);
    n_checks++;
    if (deliv_q.size() - di < 20) begin
      n_fail++;
      $display("FAIL random_progress got=%0d exp>=20", deliv_q.size() - di);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_reset_mid_wait();
    test_wrap();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
